// File: rtl/cpu_pkg.sv
// Shared CPU package: hazard control state encoding and common constants.
//   hazard_state_t : INIT / RUN / FLUSH states of the hazard control unit
//   ALU_OP_NOP     : ALU opcode carried by a killed (bubble) control word
//   REG_ZERO       : architectural zero register, never a hazard source
package cpu_pkg;

   typedef enum logic [1:0] {
      INIT  = 2'd0,
      RUN   = 2'd1,
      FLUSH = 2'd2
   } hazard_state_t;

   localparam logic [2:0] ALU_OP_NOP = 3'h1;
   localparam logic [4:0] REG_ZERO   = 5'd0;

endpackage

// File: rtl/hazard_control_unit_if.sv
// Hazard control bus between the pipeline (decode/DX/execute/fetch) and the
// hazard control unit.
//   Pipeline -> unit : id_valid, id_rs_addr, id_rt_addr, id_uses_rt,
//                      dx_mem_read, dx_rt_addr, ex_branch_taken
//   Unit -> pipeline : pc_write, fd_write, fd_flush, stall_b, ctrl_kill, busy
// modport master: pipeline side; modport slave: hazard control unit.
interface hazard_control_unit_if;

   logic       id_valid;
   logic [4:0] id_rs_addr;
   logic [4:0] id_rt_addr;
   logic       id_uses_rt;
   logic       dx_mem_read;
   logic [4:0] dx_rt_addr;
   logic       ex_branch_taken;

   logic       pc_write;
   logic       fd_write;
   logic       fd_flush;
   logic       stall_b;
   logic       ctrl_kill;
   logic       busy;

   modport master (
      output id_valid, id_rs_addr, id_rt_addr, id_uses_rt,
             dx_mem_read, dx_rt_addr, ex_branch_taken,
      input  pc_write, fd_write, fd_flush, stall_b, ctrl_kill, busy
   );

   modport slave (
      input  id_valid, id_rs_addr, id_rt_addr, id_uses_rt,
             dx_mem_read, dx_rt_addr, ex_branch_taken,
      output pc_write, fd_write, fd_flush, stall_b, ctrl_kill, busy
   );

endinterface

// File: rtl/hazard_control_unit_stat_counter.sv
// hazard_stat_counter: one saturating event counter with synchronous clear.
//   clk, rst : clock, asynchronous active-high reset (count -> 0)
//   clr_i    : synchronous clear, wins over inc_i
//   inc_i    : count one event this cycle
//   cnt_o    : current count, holds at all-ones
module hazard_stat_counter #(
   parameter int STAT_W = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clr_i,
   input  logic              inc_i,
   output logic [STAT_W-1:0] cnt_o
);

   logic [STAT_W-1:0] cnt_q;
   logic [STAT_W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (inc_i && (cnt_q != '1)) begin
         cnt_d = cnt_q + {{(STAT_W-1){1'b0}}, 1'b1};
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_o = cnt_q;

endmodule

// File: rtl/hazard_control_unit.sv
// hazard_control_unit: control-side hazard logic for the decode/DX boundary.
// Detects load-use hazards against the DX-stage load, sequences the bubbles
// that follow a taken branch, and drives PC / fetch-decode enables, the
// fetch-decode flush, the DX register stall_b and the decode control kill.
// Outputs are Mealy: a hazard acts in the same cycle it is visible.
//   clk, rst : clock, asynchronous active-high reset
//   hz       : hazard_control_unit_if.slave (pipeline inputs, control outputs)
// Optional build macro HAZARD_STATS_EN adds:
//   stat_clr_i      : synchronous clear of both statistics counters
//   stat_lu_cnt     : load-use stall cycles (saturating)
//   stat_flush_cnt  : branch flush cycles (saturating)
module hazard_control_unit
   import cpu_pkg::*;
#(
   parameter int FLUSH_CYCLES = 1,
   parameter int STAT_W       = 16
) (
   input  logic              clk,
   input  logic              rst,
`ifdef HAZARD_STATS_EN
   input  logic              stat_clr,
   output logic [STAT_W-1:0] stat_lu_cnt,
   output logic [STAT_W-1:0] stat_flush_cnt,
`endif
   hazard_control_unit_if.slave hz
);

   localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES - 1);

   hazard_state_t state_q;
   hazard_state_t state_d;
   logic [2:0]    flush_cnt_q;
   logic [2:0]    flush_cnt_d;
   logic          lu;

   // Register zero is hardwired, so a load targeting it never creates a hazard.
   always_comb begin
      lu = hz.id_valid && hz.dx_mem_read && (hz.dx_rt_addr != REG_ZERO) &&
           ((hz.dx_rt_addr == hz.id_rs_addr) ||
            (hz.id_uses_rt && (hz.dx_rt_addr == hz.id_rt_addr)));
   end

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= INIT;
         flush_cnt_q <= 3'd0;
      end else begin
         state_q     <= state_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d     = state_q;
      flush_cnt_d = flush_cnt_q;
      case (state_q)
         INIT: begin
            state_d = RUN;
         end
         RUN: begin
            // A single-cycle flush is covered by the branch cycle itself.
            if (hz.ex_branch_taken && (FLUSH_CYCLES > 1)) begin
               state_d     = FLUSH;
               flush_cnt_d = FLUSH_LOAD;
            end
         end
         FLUSH: begin
            flush_cnt_d = flush_cnt_q - 3'd1;
            if (flush_cnt_q == 3'd1) begin
               state_d = RUN;
            end
         end
         default: begin
            state_d     = INIT;
            flush_cnt_d = 3'd0;
         end
      endcase
   end

   // Output logic; rst is folded in so outputs follow reset without a clock.
   always_comb begin
      hz.pc_write  = 1'b0;
      hz.fd_write  = 1'b0;
      hz.fd_flush  = 1'b1;
      hz.stall_b   = 1'b0;
      hz.ctrl_kill = 1'b1;
      hz.busy      = 1'b1;
      if (!rst) begin
         case (state_q)
            RUN: begin
               hz.busy = 1'b0;
               if (hz.ex_branch_taken) begin
                  // Younger instruction is discarded, so a coincident lu is moot.
                  hz.pc_write  = 1'b1;
                  hz.fd_write  = 1'b1;
                  hz.fd_flush  = 1'b1;
                  hz.stall_b   = 1'b0;
                  hz.ctrl_kill = 1'b1;
               end else if (lu) begin
                  hz.pc_write  = 1'b0;
                  hz.fd_write  = 1'b0;
                  hz.fd_flush  = 1'b0;
                  hz.stall_b   = 1'b0;
                  hz.ctrl_kill = 1'b1;
               end else begin
                  hz.pc_write  = 1'b1;
                  hz.fd_write  = 1'b1;
                  hz.fd_flush  = 1'b0;
                  hz.stall_b   = 1'b1;
                  hz.ctrl_kill = 1'b0;
               end
            end
            FLUSH: begin
               hz.pc_write  = 1'b1;
               hz.fd_write  = 1'b1;
               hz.fd_flush  = 1'b1;
               hz.stall_b   = 1'b0;
               hz.ctrl_kill = 1'b1;
               hz.busy      = 1'b1;
            end
            default: begin
               hz.pc_write  = 1'b0;
               hz.fd_write  = 1'b0;
               hz.fd_flush  = 1'b1;
               hz.stall_b   = 1'b0;
               hz.ctrl_kill = 1'b1;
               hz.busy      = 1'b1;
            end
         endcase
      end
   end

`ifdef HAZARD_STATS_EN
   logic lu_event;
   logic flush_event;

   always_comb begin
      lu_event    = (state_q == RUN) && lu && !hz.ex_branch_taken;
      flush_event = ((state_q == RUN) && hz.ex_branch_taken) || (state_q == FLUSH);
   end

   hazard_stat_counter #(.STAT_W(STAT_W)) u_lu_cnt (
      .clk   (clk),
      .rst   (rst),
      .clr_i (stat_clr),
      .inc_i (lu_event),
      .cnt_o (stat_lu_cnt)
   );

   hazard_stat_counter #(.STAT_W(STAT_W)) u_flush_cnt (
      .clk   (clk),
      .rst   (rst),
      .clr_i (stat_clr),
      .inc_i (flush_event),
      .cnt_o (stat_flush_cnt)
   );
`endif

endmodule
